sp_ram_arbiter: RTL and testbench
=================================

Name: sp_ram_arbiter

Overview:
- Shares one single-port data RAM port between two requesters: master 0 (core data port) and master 1 (accelerator/DMA port).
- Uses the PULPino req/gnt/rvalid protocol with a fair round-robin policy.
- Sits directly in front of sp_ram_wrap and drives its en/addr/wdata/we/be inputs.
- Returns read data and write acknowledges to the master that owned each access.

Parameters:
- ADDR_WIDTH, 15, byte address width of the RAM port (32 KiB).
- DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8.

Ports:
- clk  in  1  system clock, rising edge.
- rstn_i  in  1  asynchronous active-low reset.
- m0_req_i  in  1  master 0 request; held with stable addr/we/be/wdata until m0_gnt_o.
- m0_gnt_o  out  1  master 0 grant, combinational.
- m0_addr_i  in  ADDR_WIDTH  master 0 byte address.
- m0_we_i  in  1  master 0 write enable.
- m0_be_i  in  DATA_WIDTH/8  master 0 byte enables.
- m0_wdata_i  in  DATA_WIDTH  master 0 write data.
- m0_rvalid_o  out  1  master 0 response valid.
- m0_rdata_o  out  DATA_WIDTH  master 0 read data.
- m1_*  same six inputs/outputs as m0_*, for master 1.
- ram_en_o  out  1  RAM enable.
- ram_addr_o  out  ADDR_WIDTH  RAM byte address.
- ram_wdata_o  out  DATA_WIDTH  RAM write data.
- ram_we_o  out  1  RAM write enable.
- ram_be_o  out  DATA_WIDTH/8  RAM byte enables.
- ram_rdata_i  in  DATA_WIDTH  RAM read data; valid one cycle after ram_en_o.

Behaviour:
- State is held in three flops:
  - last_q: last master granted. Reset value 1, so master 0 wins the first contention.
  - m0_pend_q, m1_pend_q: a response is due this cycle. Reset value 0.
- Grant (combinational, same cycle as req):
  - Only m0_req_i high: m0_gnt_o=1.
  - Only m1_req_i high: m1_gnt_o=1.
  - Both high: grant the master not equal to last_q.
  - Neither high: no grant.
  - m0_gnt_o and m1_gnt_o are never both 1.
- RAM drive:
  - ram_en_o = m0_gnt_o | m1_gnt_o.
  - ram_addr_o, ram_wdata_o, ram_we_o and ram_be_o are muxed from the granted master.
  - When no master is granted, these outputs are driven to 0.
- Pointer update: on any grant, last_q <= granted index. Otherwise last_q holds.
- Response:
  - mX_pend_q <= mX_gnt_o every cycle.
  - mX_rvalid_o = mX_pend_q, i.e. exactly 1 cycle after the grant, for reads and writes alike.
- Read data:
  - mX_rdata_o = ram_rdata_i when mX_pend_q = 1, else 0.
  - For writes, rdata content is don't-care but is still gated to 0 when not pending.
- Throughput:
  - One access per cycle.
  - A lone requester is granted every cycle (back-to-back).
  - Two continuous requesters alternate grants 0,1,0,1...
- Latency: grant in cycle N, rvalid and rdata in cycle N+1. No internal buffering; the RAM provides the 1-cycle read latency.
- Simultaneous events: a new grant in cycle N+1 while the rvalid from cycle N is presented is legal. Both masters' pend flops may be set in consecutive cycles independently.
- Reset mid-operation:
  - Asserting rstn_i clears the pend flops asynchronously, so a due rvalid is dropped.
  - last_q returns to 1.
  - The grant logic is combinational; ram_en_o follows req while in reset only if reset is deasserted. While rstn_i=0, gnt outputs and ram_en_o are forced to 0.
- Requests must not be withdrawn before grant. The arbiter does not check this; the bench flags it via assertion.

Test Plan:
- Single read: preload RAM[0x10]=0xDEADBEEF; m0 req read addr 0x10 in cycle 0.
  -> m0_gnt_o=1 in cycle 0; m0_rvalid_o=1 with m0_rdata_o=0xDEADBEEF in cycle 1; m1 outputs 0.
- Contention: m0 and m1 both request continuously for 6 cycles after reset.
  -> Grants are m0,m1,m0,m1,m0,m1; each rvalid follows its grant by exactly 1 cycle.
- Write then read with byte enables: m1 writes 0x11223344 to addr 0x20 with be=4'b0011, preceded by a full-word write of 0xFFFFFFFF; m1 then reads addr 0x20.
  -> Write rvalid after 1 cycle; read returns 0xFFFF3344.
- Lone back-to-back: m1 alone issues 4 reads to addrs 0x0,0x4,0x8,0xC.
  -> 4 consecutive grants; 4 consecutive rvalids carrying the matching data.
- Reset mid-op: m0 granted in cycle N; rstn_i pulsed low in cycle N+1 before the clock edge.
  -> No m0_rvalid_o; after release, simultaneous requests grant m0 first.
- Idle outputs: no requests for 3 cycles.
  -> ram_en_o=0, ram_addr_o=0, ram_we_o=0, ram_be_o=0, both gnt, rvalid and rdata outputs = 0.

Source files
------------

// File: rtl/sp_ram_arbiter.sv
// Two-master round-robin arbiter in front of a single-port RAM using req/gnt/rvalid.
// Grants are combinational; each response returns exactly one cycle after its grant.
module sp_ram_arbiter #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rstn_i,
    input  logic                    m0_req_i,
    output logic                    m0_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
    input  logic                    m0_we_i,
    input  logic [DATA_WIDTH/8-1:0] m0_be_i,
    input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
    output logic                    m0_rvalid_o,
    output logic [DATA_WIDTH-1:0]   m0_rdata_o,
    input  logic                    m1_req_i,
    output logic                    m1_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
    input  logic                    m1_we_i,
    input  logic [DATA_WIDTH/8-1:0] m1_be_i,
    input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
    output logic                    m1_rvalid_o,
    output logic [DATA_WIDTH-1:0]   m1_rdata_o,
    output logic                    ram_en_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    output logic                    ram_we_o,
    output logic [DATA_WIDTH/8-1:0] ram_be_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

    logic last_q, last_d;
    logic m0_pend_q, m0_pend_d;
    logic m1_pend_q, m1_pend_d;
    logic m0_win, m1_win;

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            last_q    <= 1'b1;
            m0_pend_q <= 1'b0;
            m1_pend_q <= 1'b0;
        end else begin
            last_q    <= last_d;
            m0_pend_q <= m0_pend_d;
            m1_pend_q <= m1_pend_d;
        end
    end

    // On contention the master that did not win last time gets the port.
    always_comb begin
        m0_win = 1'b0;
        m1_win = 1'b0;
        if (rstn_i) begin
            if (m0_req_i && m1_req_i) begin
                m0_win = last_q;
                m1_win = !last_q;
            end else begin
                m0_win = m0_req_i;
                m1_win = m1_req_i;
            end
        end
        last_d = last_q;
        if (m0_win) begin
            last_d = 1'b0;
        end else if (m1_win) begin
            last_d = 1'b1;
        end
        m0_pend_d = m0_win;
        m1_pend_d = m1_win;
    end

    always_comb begin
        m0_gnt_o    = m0_win;
        m1_gnt_o    = m1_win;
        ram_en_o    = m0_win | m1_win;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        ram_we_o    = 1'b0;
        ram_be_o    = '0;
        if (m0_win) begin
            ram_addr_o  = m0_addr_i;
            ram_wdata_o = m0_wdata_i;
            ram_we_o    = m0_we_i;
            ram_be_o    = m0_be_i;
        end else if (m1_win) begin
            ram_addr_o  = m1_addr_i;
            ram_wdata_o = m1_wdata_i;
            ram_we_o    = m1_we_i;
            ram_be_o    = m1_be_i;
        end
        m0_rvalid_o = m0_pend_q;
        m1_rvalid_o = m1_pend_q;
        m0_rdata_o  = m0_pend_q ? ram_rdata_i : '0;
        m1_rdata_o  = m1_pend_q ? ram_rdata_i : '0;
    end

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Bench for sp_ram_arbiter: behavioural RAM behind the arbiter, per-master expected-response queues.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_sp_ram_arbiter;
    localparam int AW = 15;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic          clk = 1'b0;
    logic          rstn_i;
    logic          m0_req_i, m0_gnt_o, m0_we_i, m0_rvalid_o;
    logic [AW-1:0] m0_addr_i;
    logic [BW-1:0] m0_be_i;
    logic [DW-1:0] m0_wdata_i, m0_rdata_o;
    logic          m1_req_i, m1_gnt_o, m1_we_i, m1_rvalid_o;
    logic [AW-1:0] m1_addr_i;
    logic [BW-1:0] m1_be_i;
    logic [DW-1:0] m1_wdata_i, m1_rdata_o;
    logic          ram_en_o, ram_we_o;
    logic [AW-1:0] ram_addr_o;
    logic [DW-1:0] ram_wdata_o, ram_rdata_i;
    logic [BW-1:0] ram_be_o;

    int checks = 0;
    int failures = 0;
    // Entry MSB set means the read data must match the low bits.
    logic [DW:0] exp0_q[$];
    logic [DW:0] exp1_q[$];

    always #5 clk = ~clk;

    sp_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rstn_i(rstn_i),
        .m0_req_i(m0_req_i), .m0_gnt_o(m0_gnt_o), .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i),
        .m0_be_i(m0_be_i), .m0_wdata_i(m0_wdata_i), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req_i), .m1_gnt_o(m1_gnt_o), .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i),
        .m1_be_i(m1_be_i), .m1_wdata_i(m1_wdata_i), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
        .ram_en_o(ram_en_o), .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o), .ram_we_o(ram_we_o),
        .ram_be_o(ram_be_o), .ram_rdata_i(ram_rdata_i)
    );

    // Preloaded content of unwritten RAM words; word 4 (byte 0x10) holds 0xDEADBEEF.
    function automatic logic [DW-1:0] pat(input int idx);
        return (idx == 4) ? 32'hDEADBEEF : (32'hC0DE0000 + DW'(idx));
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                            input logic [BW-1:0] be);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < BW; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    logic [DW-1:0] mem [0:1023];
    logic          wr_flag [0:1023];
    logic [9:0]    ram_idx;
    logic [DW-1:0] ram_cur;
    assign ram_idx = ram_addr_o[11:2];
    assign ram_cur = wr_flag[ram_idx] ? mem[ram_idx] : pat(int'(ram_idx));

    always @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < 1024; i++) wr_flag[i] <= 1'b0;
            ram_rdata_i <= '0;
        end else if (ram_en_o) begin
            if (ram_we_o) begin
                mem[ram_idx]     <= merge(ram_cur, ram_wdata_o, ram_be_o);
                wr_flag[ram_idx] <= 1'b1;
            end
            ram_rdata_i <= ram_cur;
        end
    end

    // Protocol check on the bench's own stimulus: a pending request stays up until granted.
    logic m0_wait_q, m1_wait_q;
    always @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            m0_wait_q <= 1'b0;
            m1_wait_q <= 1'b0;
        end else begin
            if (m0_wait_q) assert (m0_req_i) else $error("m0 request withdrawn before grant");
            if (m1_wait_q) assert (m1_req_i) else $error("m1 request withdrawn before grant");
            m0_wait_q <= m0_req_i && !m0_gnt_o;
            m1_wait_q <= m1_req_i && !m1_gnt_o;
        end
    end

    task automatic pulse_reset();
        @(negedge clk);
        rstn_i = 1'b0;
        @(negedge clk);
        rstn_i = 1'b1;
    endtask

    task automatic test_reset();
        rstn_i = 1'b0;
        m0_req_i = 1'b1; m1_req_i = 1'b1;
        m0_addr_i = 15'h10; m1_addr_i = 15'h20;
        m0_we_i = 1'b1; m1_we_i = 1'b1; m0_be_i = '1; m1_be_i = '1;
        m0_wdata_i = '1; m1_wdata_i = '1;
        #1;
        checks++; if (m0_gnt_o !== 1'b0 || m1_gnt_o !== 1'b0)
            begin failures++; $display("FAIL reset_gnt got=%b%b exp=00", m0_gnt_o, m1_gnt_o); end
        checks++; if (ram_en_o !== 1'b0 || ram_we_o !== 1'b0)
            begin failures++; $display("FAIL reset_ram_en got en=%b we=%b exp=0", ram_en_o, ram_we_o); end
        checks++; if (m0_rvalid_o !== 1'b0 || m1_rvalid_o !== 1'b0)
            begin failures++; $display("FAIL reset_rvalid got=%b%b exp=00", m0_rvalid_o, m1_rvalid_o); end
        repeat (2) @(negedge clk);
        m0_req_i = 1'b0; m1_req_i = 1'b0; m0_we_i = 1'b0; m1_we_i = 1'b0;
        @(negedge clk);
        rstn_i = 1'b1;
        #1;
        checks++; if (ram_addr_o !== '0 || ram_wdata_o !== '0 || ram_be_o !== '0)
            begin failures++; $display("FAIL reset_ram_bus got addr=%h wdata=%h be=%h exp=0", ram_addr_o, ram_wdata_o, ram_be_o); end
    endtask

    task automatic test_single_read();
        logic [DW:0] e;
        logic        v;
        @(negedge clk);
        m0_req_i = 1'b1; m0_we_i = 1'b0; m0_addr_i = 15'h10; m0_be_i = '1;
        #1;
        checks++; if (m0_gnt_o !== 1'b1 || m1_gnt_o !== 1'b0)
            begin failures++; $display("FAIL single_gnt got=%b%b exp=10", m0_gnt_o, m1_gnt_o); end
        checks++; if (ram_en_o !== 1'b1 || ram_addr_o !== 15'h10 || ram_we_o !== 1'b0)
            begin failures++; $display("FAIL single_ram got en=%b addr=%h we=%b exp=1/0010/0", ram_en_o, ram_addr_o, ram_we_o); end
        exp0_q.push_back({1'b1, 32'hDEADBEEF});
        @(negedge clk);
        m0_req_i = 1'b0;
        #1;
        v = (exp0_q.size() != 0);
        e = v ? exp0_q.pop_front() : '0;
        checks++; if (m0_rvalid_o !== v) begin failures++; $display("FAIL single_rvalid0 got=%b exp=%b", m0_rvalid_o, v); end
        checks++; if (m0_rdata_o !== e[DW-1:0]) begin failures++; $display("FAIL single_rdata0 got=%h exp=%h", m0_rdata_o, e[DW-1:0]); end
        checks++; if (m1_rvalid_o !== 1'b0 || m1_rdata_o !== '0 || m1_gnt_o !== 1'b0)
            begin failures++; $display("FAIL single_m1_quiet got rvalid=%b rdata=%h gnt=%b exp=0", m1_rvalid_o, m1_rdata_o, m1_gnt_o); end
    endtask

    task automatic test_contention();
        logic [DW:0]   e;
        logic          v, g0, g1;
        logic [AW-1:0] ea;
        int            n0 = 0;
        int            n1 = 0;
        pulse_reset();
        for (int i = 0; i < 8; i++) begin
            if (i != 0) @(negedge clk);
            m0_req_i = (i < 7); m1_req_i = (i < 6);
            m0_we_i = 1'b0; m1_we_i = 1'b0;
            m0_addr_i = AW'(4 * n0); m1_addr_i = AW'(16'h100 + 4 * n1);
            #1;
            v = (exp0_q.size() != 0);
            e = v ? exp0_q.pop_front() : '0;
            checks++; if (m0_rvalid_o !== v || m0_rdata_o !== e[DW-1:0])
                begin failures++; $display("FAIL contention_resp0 cyc=%0d got v=%b d=%h exp v=%b d=%h", i, m0_rvalid_o, m0_rdata_o, v, e[DW-1:0]); end
            v = (exp1_q.size() != 0);
            e = v ? exp1_q.pop_front() : '0;
            checks++; if (m1_rvalid_o !== v || m1_rdata_o !== e[DW-1:0])
                begin failures++; $display("FAIL contention_resp1 cyc=%0d got v=%b d=%h exp v=%b d=%h", i, m1_rvalid_o, m1_rdata_o, v, e[DW-1:0]); end
            g0 = (i < 6) ? (i % 2 == 0) : (i == 6);
            g1 = (i < 6) ? (i % 2 == 1) : 1'b0;
            ea = g0 ? m0_addr_i : (g1 ? m1_addr_i : '0);
            checks++; if (m0_gnt_o !== g0 || m1_gnt_o !== g1)
                begin failures++; $display("FAIL contention_gnt cyc=%0d got=%b%b exp=%b%b", i, m0_gnt_o, m1_gnt_o, g0, g1); end
            checks++; if (ram_en_o !== (g0 | g1) || ram_addr_o !== ea)
                begin failures++; $display("FAIL contention_ram cyc=%0d got en=%b addr=%h exp en=%b addr=%h", i, ram_en_o, ram_addr_o, g0 | g1, ea); end
            if (g0) begin exp0_q.push_back({1'b1, pat(n0)}); n0++; end
            if (g1) begin exp1_q.push_back({1'b1, pat(64 + n1)}); n1++; end
        end
    endtask

    task automatic test_write_be();
        logic [DW:0]   e;
        logic          v;
        logic [DW-1:0] wd [3];
        logic [BW-1:0] be [3];
        wd[0] = 32'hFFFFFFFF; be[0] = 4'b1111;
        wd[1] = 32'h11223344; be[1] = 4'b0011;
        wd[2] = 32'h00000000; be[2] = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            m1_req_i = (i < 3); m1_addr_i = 15'h20; m1_we_i = (i < 2);
            m1_wdata_i = wd[i % 3]; m1_be_i = be[i % 3];
            #1;
            v = (exp1_q.size() != 0);
            e = v ? exp1_q.pop_front() : '0;
            checks++; if (m1_rvalid_o !== v) begin failures++; $display("FAIL wbe_rvalid cyc=%0d got=%b exp=%b", i, m1_rvalid_o, v); end
            checks++; if (v && e[DW] && m1_rdata_o !== e[DW-1:0])
                begin failures++; $display("FAIL wbe_rdata cyc=%0d got=%h exp=%h", i, m1_rdata_o, e[DW-1:0]); end
            if (i < 3) begin
                checks++; if (m1_gnt_o !== 1'b1 || ram_we_o !== m1_we_i || ram_be_o !== m1_be_i || ram_wdata_o !== m1_wdata_i)
                    begin failures++; $display("FAIL wbe_ram cyc=%0d got gnt=%b we=%b be=%h wd=%h exp 1/%b/%h/%h", i, m1_gnt_o, ram_we_o, ram_be_o, ram_wdata_o, m1_we_i, m1_be_i, m1_wdata_i); end
                exp1_q.push_back((i < 2) ? {1'b0, 32'h0} : {1'b1, 32'hFFFF3344});
            end
        end
        m1_we_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [DW:0] e;
        logic        v;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            m1_req_i = (i < 4); m1_we_i = 1'b0; m1_be_i = '1; m1_addr_i = AW'(4 * i);
            #1;
            v = (exp1_q.size() != 0);
            e = v ? exp1_q.pop_front() : '0;
            checks++; if (m1_rvalid_o !== v || m1_rdata_o !== e[DW-1:0])
                begin failures++; $display("FAIL b2b_resp cyc=%0d got v=%b d=%h exp v=%b d=%h", i, m1_rvalid_o, m1_rdata_o, v, e[DW-1:0]); end
            checks++; if (m1_gnt_o !== (i < 4) || m0_gnt_o !== 1'b0)
                begin failures++; $display("FAIL b2b_gnt cyc=%0d got=%b%b exp=0%b", i, m0_gnt_o, m1_gnt_o, (i < 4)); end
            if (i < 4) exp1_q.push_back({1'b1, pat(i)});
        end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            m0_req_i = 1'b0; m1_req_i = 1'b0;
            m0_addr_i = AW'($urandom_range(0, 32767)); m1_addr_i = AW'($urandom_range(0, 32767));
            m0_we_i = 1'b1; m1_we_i = 1'b1; m0_be_i = '1; m1_be_i = '1;
            #1;
            checks++; if (ram_en_o !== 1'b0 || ram_addr_o !== '0 || ram_we_o !== 1'b0 || ram_be_o !== '0 || ram_wdata_o !== '0)
                begin failures++; $display("FAIL idle_ram cyc=%0d got en=%b addr=%h we=%b be=%h exp all 0", i, ram_en_o, ram_addr_o, ram_we_o, ram_be_o); end
            checks++; if ({m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o} !== 4'b0 || m0_rdata_o !== '0 || m1_rdata_o !== '0)
                begin failures++; $display("FAIL idle_master cyc=%0d got gnt=%b%b rv=%b%b rd=%h/%h exp 0", i, m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, m0_rdata_o, m1_rdata_o); end
        end
        m0_we_i = 1'b0; m1_we_i = 1'b0;
    endtask

    task automatic test_reset_midop();
        @(negedge clk);
        m0_req_i = 1'b1; m0_addr_i = 15'h10; m0_we_i = 1'b0;
        #1;
        checks++; if (m0_gnt_o !== 1'b1) begin failures++; $display("FAIL midop_gnt got=%b exp=1", m0_gnt_o); end
        @(negedge clk);
        m0_req_i = 1'b0;
        #1;
        checks++; if (m0_rvalid_o !== 1'b1) begin failures++; $display("FAIL midop_pre_rvalid got=%b exp=1", m0_rvalid_o); end
        rstn_i = 1'b0;
        m0_req_i = 1'b1; m1_req_i = 1'b1;
        #1;
        checks++; if (m0_rvalid_o !== 1'b0 || m0_rdata_o !== '0)
            begin failures++; $display("FAIL midop_dropped got v=%b d=%h exp 0", m0_rvalid_o, m0_rdata_o); end
        checks++; if (m0_gnt_o !== 1'b0 || m1_gnt_o !== 1'b0 || ram_en_o !== 1'b0)
            begin failures++; $display("FAIL midop_forced got gnt=%b%b en=%b exp 0", m0_gnt_o, m1_gnt_o, ram_en_o); end
        @(negedge clk);
        rstn_i = 1'b1;
        #1;
        checks++; if (m0_gnt_o !== 1'b1 || m1_gnt_o !== 1'b0)
            begin failures++; $display("FAIL midop_first_gnt got=%b%b exp=10", m0_gnt_o, m1_gnt_o); end
        @(negedge clk);
        m0_req_i = 1'b0;
        #1;
        checks++; if (m0_rvalid_o !== 1'b1 || m1_gnt_o !== 1'b1)
            begin failures++; $display("FAIL midop_second got rv0=%b gnt1=%b exp 1/1", m0_rvalid_o, m1_gnt_o); end
        @(negedge clk);
        m1_req_i = 1'b0;
        #1;
        checks++; if (m1_rvalid_o !== 1'b1 || m0_rvalid_o !== 1'b0)
            begin failures++; $display("FAIL midop_resp1 got rv=%b%b exp=01", m0_rvalid_o, m1_rvalid_o); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_write_be();
        test_back_to_back();
        test_idle();
        test_reset_midop();
        checks++; if (exp0_q.size() != 0 || exp1_q.size() != 0)
            begin failures++; $display("FAIL leftover_responses got=%0d/%0d exp=0/0", exp0_q.size(), exp1_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
